// File: rtl/plate_ctrl.sv
// Paddle ("plate") controller: a bounded horizontal bar with auto-repeat movement
// and a timed length boost. Outputs decode directly from the registered pos/len.
module plate_ctrl #(
    parameter int ROW_W       = 16,
    parameter int PLATE_LEN   = 4,
    parameter int GROW_EXTRA  = 2,
    parameter int INIT_POS    = 6,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 2,
    parameter int BOOST_TICKS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [3:0]                   control,
    input  logic                         tick,
    input  logic                         grow,
    output logic [ROW_W-1:0]             data_out,
    output logic [$clog2(ROW_W)-1:0]     pos,
    output logic [$clog2(ROW_W+1)-1:0]   len,
    output logic                         at_right,
    output logic                         at_left,
    output logic                         boost_active,
    output logic [1:0]                   fsm_state
);
    localparam int PW        = $clog2(ROW_W);
    localparam int LW        = $clog2(ROW_W + 1);
    localparam int BOOST_LEN = PLATE_LEN + GROW_EXTRA;
    localparam int CNT_MAX   = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int TW        = $clog2(BOOST_TICKS + 1);

    // Handshake: none. control/grow are level/pulse inputs; control is only
    // consumed on cycles where tick=1, grow is consumed on every cycle.

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [3:0]      cmd_r, cmd_n;
    logic [TW-1:0]   timer_r, timer_n;
    logic [PW-1:0]   pos_n;
    logic [LW-1:0]   len_n;
    logic            is_move;
    logic            do_move;
    int              p;
    int              lim;
    int              step;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            cmd_r   <= '0;
            timer_r <= '0;
            pos     <= PW'(INIT_POS);
            len     <= LW'(PLATE_LEN);
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            cmd_r   <= cmd_n;
            timer_r <= timer_n;
            pos     <= pos_n;
            len     <= len_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        cmd_n   = cmd_r;
        timer_n = timer_r;
        len_n   = len;
        do_move = 1'b0;
        is_move = (control == 4'b0001) || (control == 4'b0011) ||
                  (control == 4'b0100) || (control == 4'b0110);
        p       = int'(pos);
        lim     = 0;
        step    = control[1] ? 2 : 1;

        if (tick) begin
            if (!is_move) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (state_r == IDLE || control != cmd_r) begin
                do_move = 1'b1;
                cmd_n   = control;
                state_n = DELAY;
                cnt_n   = '0;
            end else if (state_r == DELAY) begin
                if (cnt_r == CW'(REPEAT_DLY - 1)) begin
                    do_move = 1'b1;
                    state_n = REPEAT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end else begin
                if (cnt_r == CW'(REPEAT_RATE - 1)) begin
                    do_move = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
        end

        // Grow takes priority over expiry and is applied before any move.
        if (grow) begin
            len_n   = LW'(BOOST_LEN);
            timer_n = TW'(BOOST_TICKS);
            if (p > ROW_W - BOOST_LEN) p = ROW_W - BOOST_LEN;
        end else if (tick && timer_r != '0) begin
            timer_n = timer_r - 1'b1;
            if (timer_r == TW'(1)) len_n = LW'(PLATE_LEN);
        end

        lim = ROW_W - int'(len_n);
        if (do_move) begin
            if (control[2]) begin
                if (p + step <= lim)  p = p + step;
                else if (p + 1 <= lim) p = p + 1;
            end else begin
                if (p >= step)  p = p - step;
                else if (p >= 1) p = p - 1;
            end
        end
        pos_n = PW'(p);
    end

    logic [ROW_W:0] ones;
    always_comb begin
        ones         = ((ROW_W+1)'(1) << len) - (ROW_W+1)'(1);
        data_out     = ones[ROW_W-1:0] << pos;
        at_right     = (pos == '0);
        at_left      = (LW'(pos) == LW'(ROW_W) - len);
        boost_active = (len == LW'(BOOST_LEN));
        fsm_state    = state_r;
    end
endmodule

// File: tb/tb_plate_ctrl.sv
// Self-checking bench for plate_ctrl: directed scenarios plus a random phase,
// all cycles compared against a behavioural model through a scoreboard queue.
module tb_plate_ctrl;
    logic        clock;
    logic        reset;
    logic [3:0]  control;
    logic        tick;
    logic        grow;
    logic [15:0] data_out;
    logic [3:0]  pos;
    logic [4:0]  len;
    logic        at_right;
    logic        at_left;
    logic        boost_active;
    logic [1:0]  fsm_state;

    plate_ctrl dut (
        .clock(clock), .reset(reset), .control(control), .tick(tick), .grow(grow),
        .data_out(data_out), .pos(pos), .len(len), .at_right(at_right),
        .at_left(at_left), .boost_active(boost_active), .fsm_state(fsm_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    // Behavioural model: age counts ticks since the current command's first move.
    int         m_pos, m_len, m_timer, m_age;
    logic [3:0] m_cmd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] c, input logic t, input logic g);
        logic mv;
        int   tgt;
        mv = 1'b0;
        if (r) begin
            m_pos = 6; m_len = 4; m_timer = 0; m_age = -1; m_cmd = 4'b0;
            return;
        end
        if (t) begin
            if (c == 4'b0001 || c == 4'b0011 || c == 4'b0100 || c == 4'b0110) begin
                if (m_age < 0 || c != m_cmd) begin
                    m_cmd = c; m_age = 0; mv = 1'b1;
                end else begin
                    m_age++;
                    mv = (m_age == 4) || (m_age > 4 && (m_age - 4) % 2 == 0);
                end
            end else begin
                m_age = -1;
            end
        end
        if (g) begin
            m_len = 6; m_timer = 8;
            if (m_pos > 10) m_pos = 10;
        end else if (t && m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) m_len = 4;
        end
        if (mv) begin
            tgt = c[2] ? m_pos + (c[1] ? 2 : 1) : m_pos - (c[1] ? 2 : 1);
            if (tgt < 0) tgt = 0;
            if (tgt > 16 - m_len) tgt = 16 - m_len;
            m_pos = tgt;
        end
    endtask

    function automatic logic [31:0] pack_model();
        logic [15:0] d;
        d = '0;
        for (int i = 0; i < 16; i++)
            if (i >= m_pos && i < m_pos + m_len) d[i] = 1'b1;
        return {4'b0, d, 4'(m_pos), 5'(m_len), (m_len == 6), (m_pos == 16 - m_len), (m_pos == 0)};
    endfunction

    task automatic drive_cycle(input logic r, input logic [3:0] c, input logic t, input logic g);
        logic [31:0] e;
        reset = r; control = c; tick = t; grow = g;
        model_step(r, c, t, g);
        exp_q.push_back(pack_model());
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check("outputs", {4'b0, data_out, pos, len, boost_active, at_left, at_right}, e);
    endtask

    initial begin
        int         rpt_tbl[9];
        logic [3:0] c;
        int         sel;
        reset = 1'b1; control = 4'b0; tick = 1'b0; grow = 1'b0;
        m_pos = 6; m_len = 4; m_timer = 0; m_age = -1; m_cmd = 4'b0;

        // Reset state
        drive_cycle(1, 4'b0000, 0, 0);
        drive_cycle(1, 4'b0001, 1, 1);
        check("rst_data", 32'(data_out), 32'h03C0);
        check("rst_pos", 32'(pos), 32'd6);
        check("rst_len", 32'(len), 32'd4);
        check("rst_boost", 32'(boost_active), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);

        // Auto-repeat right from 6
        rpt_tbl = '{5, 5, 5, 5, 4, 4, 3, 3, 2};
        for (int k = 0; k < 9; k++) begin
            drive_cycle(0, 4'b0001, 1, 0);
            check("rpt_pos", 32'(pos), 32'(rpt_tbl[k]));
        end

        // Walk left to 11, then clamped step-2 at the left wall
        drive_cycle(1, 4'b0000, 0, 0);
        for (int k = 0; k < 11; k++) drive_cycle(0, 4'b0100, 1, 0);
        check("walk_pos", 32'(pos), 32'd11);
        drive_cycle(0, 4'b0000, 1, 0);
        drive_cycle(0, 4'b0110, 1, 0);
        check("clamp_pos", 32'(pos), 32'd12);
        check("clamp_left", 32'(at_left), 32'd1);
        drive_cycle(0, 4'b0110, 1, 0);
        check("wall_pos", 32'(pos), 32'd12);

        // Grow at the wall pulls pos in; expiry after 8 ticks
        drive_cycle(0, 4'b0000, 0, 1);
        check("grow_len", 32'(len), 32'd6);
        check("grow_pos", 32'(pos), 32'd10);
        check("grow_data", 32'(data_out), 32'hFC00);
        for (int k = 0; k < 7; k++) drive_cycle(0, 4'b0000, 1, 0);
        check("boost_hold", 32'(boost_active), 32'd1);
        drive_cycle(0, 4'b0000, 1, 0);
        check("exp_len", 32'(len), 32'd4);
        check("exp_pos", 32'(pos), 32'd10);
        check("exp_boost", 32'(boost_active), 32'd0);

        // Grow coinciding with expiry keeps the boost
        drive_cycle(0, 4'b0000, 0, 1);
        for (int k = 0; k < 7; k++) drive_cycle(0, 4'b0000, 1, 0);
        drive_cycle(0, 4'b0000, 1, 1);
        check("grow_wins", 32'(boost_active), 32'd1);
        for (int k = 0; k < 8; k++) drive_cycle(0, 4'b0000, 1, 0);
        check("reexpire", 32'(len), 32'd4);

        // Grow with a move: move is clamped against the boosted length
        drive_cycle(0, 4'b0110, 1, 1);
        check("grow_move_pos", 32'(pos), 32'd10);
        drive_cycle(1, 4'b0000, 1, 0);
        check("rst_boost_abort", 32'(len), 32'd4);

        // Direction toggle restarts the delay
        drive_cycle(0, 4'b0001, 1, 0);
        check("tog_pos1", 32'(pos), 32'd5);
        drive_cycle(0, 4'b0100, 1, 0);
        check("tog_pos2", 32'(pos), 32'd6);
        check("tog_state", 32'(fsm_state), 32'd1);

        // control ignored without tick; reset mid-DELAY
        for (int k = 0; k < 20; k++) drive_cycle(0, 4'b0011, 0, 0);
        check("notick_pos", 32'(pos), 32'd6);
        drive_cycle(0, 4'b0001, 1, 0);
        drive_cycle(0, 4'b0001, 1, 0);
        drive_cycle(1, 4'b0001, 1, 0);
        check("mid_rst_pos", 32'(pos), 32'd6);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        drive_cycle(0, 4'b0000, 1, 0);
        check("no_residual", 32'(pos), 32'd6);

        // Random phase
        c = 4'b0001;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1:    c = 4'b0001;
                    2:       c = 4'b0011;
                    3, 4:    c = 4'b0100;
                    5:       c = 4'b0110;
                    6:       c = 4'b1111;
                    7:       c = 4'b0000;
                    default: c = 4'($urandom_range(0, 15));
                endcase
            end
            drive_cycle($urandom_range(0, 199) == 0, c, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
